// File: rtl/frac_clock_divider_pkg.sv
// Shared types and constants for the fractional UART sample-clock divider.
package frac_clock_divider_pkg;

  // Default divisor field widths (integer part, fractional part in 1/2^W units)
  localparam int DIV_INT_W  = 16;
  localparam int DIV_FRAC_W = 4;

  // Smallest integer divisor that still yields a period of at least two cycles
  localparam int MIN_DIV_INT = 2;

  typedef logic [DIV_INT_W-1:0]  div_int_t;
  typedef logic [DIV_FRAC_W-1:0] div_frac_t;

  typedef struct packed {
    div_int_t  int_part;
    div_frac_t frac_part;
  } divisor_t;

  // True when a requested integer divisor can be accepted
  function automatic logic div_int_legal(input logic [31:0] v);
    return (v >= 32'(MIN_DIV_INT));
  endfunction

endpackage

// File: rtl/frac_clock_divider_modulo_counter.sv
// Modulo-MOD event counter with synchronous clear; o_wrap flags the counted
// event that takes the count from MOD-1 back to 0.
module modulo_counter #(
  parameter  int MOD = 16,
  localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] r_count;

  assign o_wrap  = i_en && (r_count == LAST);
  assign o_count = r_count;

  // Count enabled events, wrapping at MOD; clear takes priority over counting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/frac_clock_divider.sv
// Runtime-programmable fractional divider producing the UART sample tick,
// the oversampled bit tick and a toggling divided clock. A new divisor is
// staged in a shadow register and only takes effect at a period boundary,
// while idle, or on resync, so the tick stream never glitches.
module frac_clock_divider
  import frac_clock_divider_pkg::*;
#(
  parameter int INT_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RESET_DIV_INT  = 16,
  parameter int RESET_DIV_FRAC = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              resync,
  input  logic              load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              clk_out,
  output logic              load_pend,
  output logic              div_err
);

  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $fatal(1, "frac_clock_divider: OVERSAMPLE must be >= 2");
  end
  if (RESET_DIV_INT < MIN_DIV_INT) begin : g_bad_reset_div
    $fatal(1, "frac_clock_divider: RESET_DIV_INT must be >= 2");
  end

  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
  } div_t;

  localparam int             OS_CW     = $clog2(OVERSAMPLE);
  localparam logic [OS_CW-1:0] OS_LAST = OS_CW'(OVERSAMPLE - 1);
  localparam div_t           RESET_DIV = {INT_W'(RESET_DIV_INT), FRAC_W'(RESET_DIV_FRAC)};

  // Period counter and fractional accumulator
  logic [INT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;

  // Active and staged divisors
  div_t r_act;
  div_t r_shadow;
  logic r_load_pend;

  // Registered outputs
  logic r_sample_tick;
  logic r_bit_tick;
  logic r_clk_out;
  logic r_div_err;

  logic [INT_W:0]    w_len_m1;
  logic [FRAC_W:0]   w_sum;
  logic              w_period_end;
  logic              w_hold;
  logic              w_load_ok;
  logic              w_load_bad;
  logic              w_apply;
  logic [OS_CW-1:0]  w_os_cnt;
  logic              w_os_wrap;

  // Current period is act_int cycles, stretched by one when the accumulator carried
  assign w_len_m1     = {1'b0, r_act.int_part} + (INT_W+1)'(r_extra) - (INT_W+1)'(1);
  assign w_sum        = {1'b0, r_acc} + {1'b0, r_act.frac_part};
  assign w_hold       = !enable || resync;
  assign w_period_end = !w_hold && ({1'b0, r_cnt} == w_len_m1);

  assign w_load_ok  = load && div_int_legal(32'(div_int));
  assign w_load_bad = load && !div_int_legal(32'(div_int));
  // Only a request registered before this edge may be applied, so a load that
  // coincides with a period end waits for the following boundary
  assign w_apply    = r_load_pend && (w_hold || w_period_end);

  // Period counter and accumulator; a newly applied divisor restarts the fraction
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (w_hold) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (w_period_end) begin
      r_cnt <= '0;
      if (w_apply) begin
        r_acc   <= '0;
        r_extra <= 1'b0;
      end else begin
        r_acc   <= w_sum[FRAC_W-1:0];
        r_extra <= w_sum[FRAC_W];
      end
    end else begin
      r_cnt <= r_cnt + INT_W'(1);
    end
  end

  // Divisor staging: accept legal loads into the shadow, transfer at a boundary
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_act       <= RESET_DIV;
      r_shadow    <= RESET_DIV;
      r_load_pend <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act <= r_shadow;
      end
      if (w_load_ok) begin
        r_shadow <= {div_int, div_frac};
      end
      r_load_pend <= w_load_ok || (r_load_pend && !w_apply);
    end
  end

  // Oversample phase counter, advanced once per sample tick
  modulo_counter #(
    .MOD (OVERSAMPLE)
  ) u_os_cnt (
    .i_clk   (clk_in),
    .i_rst_n (rst),
    .i_en    (w_period_end),
    .i_clr   (w_hold),
    .o_count (w_os_cnt),
    .o_wrap  (w_os_wrap)
  );

  // Output pulses and divided clock, all registered
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sample_tick <= 1'b0;
      r_bit_tick    <= 1'b0;
      r_clk_out     <= 1'b0;
      r_div_err     <= 1'b0;
    end else begin
      r_sample_tick <= w_period_end;
      r_bit_tick    <= w_os_wrap && (w_os_cnt == OS_LAST);
      r_div_err     <= w_load_bad;
      if (w_period_end) begin
        r_clk_out <= !r_clk_out;
      end
    end
  end

  assign sample_tick = r_sample_tick;
  assign bit_tick    = r_bit_tick;
  assign clk_out     = r_clk_out;
  assign load_pend   = r_load_pend;
  assign div_err     = r_div_err;

endmodule

// File: tb/tb_frac_clock_divider.sv
// Directed bench for frac_clock_divider (default parameters: 16-bit int,
// 4-bit fraction, OVERSAMPLE=16, reset divisor 16.0).
module tb_frac_clock_divider;
  import frac_clock_divider_pkg::*;

  logic      clk_in;
  logic      rst;
  logic      enable;
  logic      resync;
  logic      load;
  div_int_t  div_int;
  div_frac_t div_frac;
  logic      sample_tick;
  logic      bit_tick;
  logic      clk_out;
  logic      load_pend;
  logic      div_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int parity   = 0;
  int tick_q[$];
  int bit_q[$];
  int clk_q[$];
  int c0;
  int t0;

  frac_clock_divider dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .resync      (resync),
    .load        (load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .clk_out     (clk_out),
    .load_pend   (load_pend),
    .div_err     (div_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Record tick times (cycle index of the producing edge) and clk_out at each tick
  always @(posedge clk_in) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      parity = 0;
    end else begin
      if (sample_tick) begin
        parity = parity ^ 1;
        tick_q.push_back(cyc);
        clk_q.push_back(int'(clk_out));
      end
      if (bit_tick) bit_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int first_after(input int q[$], input int t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return -1;
  endfunction

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    @(negedge clk_in);
    while (!sample_tick && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("wait_tick", int'(sample_tick), 1);
  endtask

  task automatic clear_logs();
    tick_q.delete();
    bit_q.delete();
    clk_q.delete();
  endtask

  // Load a divisor while disabled: accepted on one edge, applied on the next
  task automatic load_idle(input int di, input int df);
    enable   = 1'b0;
    @(negedge clk_in);
    load     = 1'b1;
    div_int  = div_int_t'(di);
    div_frac = div_frac_t'(df);
    @(negedge clk_in);
    load = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; resync = 1'b0; load = 1'b0;
    div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_sample_tick", int'(sample_tick), 0);
    check_eq("rst_bit_tick",    int'(bit_tick),    0);
    check_eq("rst_clk_out",     int'(clk_out),     0);
    check_eq("rst_load_pend",   int'(load_pend),   0);
    check_eq("rst_div_err",     int'(div_err),     0);

    // A: 4.0 loaded while idle, then run
    rst = 1'b1;
    load = 1'b1; div_int = 4; div_frac = 0;
    @(negedge clk_in);
    load = 1'b0;
    check_eq("a_pend_set", int'(load_pend), 1);
    @(negedge clk_in);
    check_eq("a_pend_idle_apply", int'(load_pend), 0);
    clear_logs();
    c0 = cyc;
    enable = 1'b1;
    repeat (140) @(negedge clk_in);
    check_eq("a_first_tick", qget(tick_q, 0) - c0, 4);
    for (int i = 0; i < 3; i++)
      check_eq("a_interval", qget(tick_q, i + 1) - qget(tick_q, i), 4);
    check_eq("a_clk_out_t0", qget(clk_q, 0), 1);
    check_eq("a_clk_out_t1", qget(clk_q, 1), 0);
    check_eq("a_clk_out_t2", qget(clk_q, 2), 1);
    check_eq("a_bit_tick_0", qget(bit_q, 0) - c0, 64);
    check_eq("a_bit_tick_1", qget(bit_q, 1) - c0, 128);

    // C: 3 + 8/16 -> 3,3,4,3,4,...
    enable = 1'b0;
    @(negedge clk_in);
    check_eq("c_clk_out_hold", int'(clk_out), parity);
    load_idle(3, 8);
    clear_logs();
    c0 = cyc;
    enable = 1'b1;
    repeat (130) @(negedge clk_in);
    check_eq("c_first_tick", qget(tick_q, 0) - c0, 3);
    check_eq("c_interval_1", qget(tick_q, 1) - qget(tick_q, 0), 3);
    check_eq("c_interval_2", qget(tick_q, 2) - qget(tick_q, 1), 4);
    check_eq("c_interval_3", qget(tick_q, 3) - qget(tick_q, 2), 3);
    check_eq("c_interval_4", qget(tick_q, 4) - qget(tick_q, 3), 4);
    check_eq("c_32_intervals", qget(tick_q, 32) - qget(tick_q, 0), 112);

    // D: load 6 mid-period of a 4-cycle stream
    load_idle(4, 0);
    clear_logs();
    enable = 1'b1;
    repeat (10) @(negedge clk_in);
    wait_tick(20);
    t0 = cyc;
    @(negedge clk_in);
    load = 1'b1; div_int = 6; div_frac = 0;
    @(negedge clk_in);
    load = 1'b0;
    check_eq("d_pend_t2", int'(load_pend), 1);
    @(negedge clk_in);
    check_eq("d_pend_t3", int'(load_pend), 1);
    @(negedge clk_in);
    check_eq("d_tick_t4", int'(sample_tick), 1);
    check_eq("d_pend_cleared", int'(load_pend), 0);
    repeat (14) @(negedge clk_in);
    check_eq("d_tick_old_len", first_after(tick_q, t0) - t0, 4);
    check_eq("d_tick_new_len1", first_after(tick_q, t0 + 4) - t0, 10);
    check_eq("d_tick_new_len2", first_after(tick_q, t0 + 10) - t0, 16);

    // E: illegal load (int=1) rejected
    load = 1'b1; div_int = 1; div_frac = 0;
    @(negedge clk_in);
    load = 1'b0;
    check_eq("e_div_err_pulse", int'(div_err), 1);
    check_eq("e_pend_stays_0", int'(load_pend), 0);
    @(negedge clk_in);
    check_eq("e_div_err_end", int'(div_err), 0);
    repeat (10) @(negedge clk_in);
    check_eq("e_interval_a", first_after(tick_q, t0 + 16) - t0, 22);
    check_eq("e_interval_b", first_after(tick_q, t0 + 22) - t0, 28);

    // F: resync at cnt=2 of a 10-cycle period
    load_idle(10, 0);
    clear_logs();
    enable = 1'b1;
    wait_tick(30);
    wait_tick(30);
    wait_tick(30);
    t0 = cyc;
    @(negedge clk_in);
    @(negedge clk_in);
    resync = 1'b1;
    @(negedge clk_in);
    resync = 1'b0;
    check_eq("f_clk_out_kept", int'(clk_out), parity);
    repeat (170) @(negedge clk_in);
    check_eq("f_next_tick", first_after(tick_q, t0) - t0, 13);
    check_eq("f_bit_tick", first_after(bit_q, t0) - t0, 163);
    check_eq("f_clk_out_track", int'(clk_out), parity);

    // G: async reset mid-cycle with pending load and clk_out high
    wait_tick(15);
    if (parity != 0) wait_tick(15);
    repeat (9) @(negedge clk_in);
    load = 1'b1; div_int = 7; div_frac = 0;
    @(negedge clk_in);
    load = 1'b0;
    check_eq("g_tick_with_load", int'(sample_tick), 1);
    check_eq("g_pend_after_end", int'(load_pend), 1);
    check_eq("g_clk_out_high", int'(clk_out), 1);
    #1 rst = 1'b0;
    #1;
    check_eq("g_async_sample_tick", int'(sample_tick), 0);
    check_eq("g_async_clk_out", int'(clk_out), 0);
    check_eq("g_async_load_pend", int'(load_pend), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    clear_logs();
    c0 = cyc;
    repeat (40) @(negedge clk_in);
    check_eq("g_first_tick_reset_div", qget(tick_q, 0) - c0, 16);
    check_eq("g_second_interval", qget(tick_q, 1) - qget(tick_q, 0), 16);
    check_eq("g_clk_out_first", qget(clk_q, 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
